prng256_sched: RTL and testbench

- Sequencer for the 256-bit AES-CTR PRNG datapath (two pipelined AES cores sharing key, prefix and counter).
- On a start command it latches key, prefix, base counter and block count. It then issues one counter value per cycle into the PRNG, gated by credits.
- It captures each 256-bit result into an output FIFO and presents the results as a valid/ready stream to the correlated-randomness consumer.
- Credit-based flow control means a result is never dropped, whatever the PRNG pipeline latency.

---
 rtl/prng256_sched.sv | 178 +++++++++++++++++
 tb/tb_prng256_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng256_sched.sv
// prng256_sched: job sequencer for the 256-bit AES-CTR PRNG datapath.
// It latches a job on start and issues one counter per cycle, gated by credits.
// It captures PRNG results into an output FIFO and streams them out as valid/ready.
// Optional build macro PRNG256_SCHED_ABORT_EN adds an abort input that
// cancels the running job.
module prng256_sched #(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [127:0]       cfg_key,
    input  logic [6:0]         cfg_prefix,
    input  logic [CNT_W-1:0]   cfg_cnt_base,
    input  logic [CNT_W-1:0]   cfg_nblk,
    input  logic               start,
`ifdef PRNG256_SCHED_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic [127:0]       prng_kin,
    output logic [6:0]         prng_prefix,
    output logic [CNT_W-1:0]   prng_cnt,
    output logic               prng_drdy,
    input  logic               prng_dvld,
    input  logic [255:0]       prng_dout,
    output logic [255:0]       m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               err_unexp
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0] DEPTH_V = (OCC_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   remaining_reg;
    logic [CNT_W-1:0]   next_cnt_reg;
    logic [OCC_W-1:0]   inflight_reg, inflight_next;
    logic [OCC_W-1:0]   fifo_count_reg, fifo_count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [255:0]       fifo_mem [FIFO_DEPTH];
    logic               prng_drdy_reg;
    logic [CNT_W-1:0]   prng_cnt_reg;
    logic [127:0]       prng_kin_reg;
    logic [6:0]         prng_prefix_reg;
    logic               err_unexp_reg;
    logic               discard_reg;

    logic               issue, capture, push, pop, flush, credit_ok, abort_hit;

`ifdef PRNG256_SCHED_ABORT_EN
    assign abort_hit = abort && ((state_reg == RUN) || (state_reg == DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // Credit check, FIFO/inflight bookkeeping and next-state decode.
    always_comb begin
        state_next      = state_reg;
        issue           = 1'b0;
        flush           = abort_hit;
        credit_ok       = ({1'b0, fifo_count_reg} + {1'b0, inflight_reg}) < DEPTH_V;
        capture         = prng_dvld && (inflight_reg != '0);
        push            = capture && !discard_reg && !flush;
        pop             = (fifo_count_reg != '0) && m_ready && !flush;
        inflight_next   = inflight_reg;
        fifo_count_next = fifo_count_reg;

        if ((state_reg == RUN) && !abort_hit && (remaining_reg != '0) && credit_ok)
            issue = 1'b1;

        case ({issue, capture})
            2'b10:   inflight_next = inflight_reg + OCC_W'(1);
            2'b01:   inflight_next = inflight_reg - OCC_W'(1);
            default: inflight_next = inflight_reg;
        endcase

        if (flush) begin
            fifo_count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_count_next = fifo_count_reg + OCC_W'(1);
                2'b01:   fifo_count_next = fifo_count_reg - OCC_W'(1);
                default: fifo_count_next = fifo_count_reg;
            endcase
        end

        case (state_reg)
            IDLE:  if (start) state_next = (cfg_nblk == '0) ? DONE : RUN;
            RUN: begin
                if (abort_hit)
                    state_next = DRAIN;
                else if (issue && (remaining_reg == CNT_W'(1)))
                    state_next = DRAIN;
            end
            // Leave as soon as the final beat is popped, so done follows it directly.
            DRAIN: if ((inflight_next == '0) && (fifo_count_next == '0)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state, job registers and registered PRNG interface.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= IDLE;
            remaining_reg   <= '0;
            next_cnt_reg    <= '0;
            inflight_reg    <= '0;
            fifo_count_reg  <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            prng_drdy_reg   <= 1'b0;
            prng_cnt_reg    <= '0;
            prng_kin_reg    <= '0;
            prng_prefix_reg <= '0;
            err_unexp_reg   <= 1'b0;
            discard_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            inflight_reg   <= inflight_next;
            fifo_count_reg <= fifo_count_next;
            prng_drdy_reg  <= issue;

            if ((state_reg == IDLE) && start) begin
                remaining_reg   <= cfg_nblk;
                next_cnt_reg    <= cfg_cnt_base;
                prng_kin_reg    <= cfg_key;
                prng_prefix_reg <= cfg_prefix;
            end else if (issue) begin
                prng_cnt_reg  <= next_cnt_reg;
                next_cnt_reg  <= next_cnt_reg + CNT_W'(1);
                remaining_reg <= remaining_reg - CNT_W'(1);
            end else if (abort_hit) begin
                remaining_reg <= '0;
            end

            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end

            // A result with nothing outstanding means the PRNG was not reset with us.
            if (prng_dvld && (inflight_reg == '0))
                err_unexp_reg <= 1'b1;

            if (flush)
                discard_reg <= 1'b1;
            else if (state_reg == DONE)
                discard_reg <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= prng_dout;
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign prng_drdy   = prng_drdy_reg;
    assign prng_cnt    = prng_cnt_reg;
    assign prng_kin    = prng_kin_reg;
    assign prng_prefix = prng_prefix_reg;
    assign m_valid     = (fifo_count_reg != '0);
    assign m_data      = m_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign err_unexp   = err_unexp_reg;

endmodule

// File: tb/tb_prng256_sched.sv
// tb_prng256_sched: directed bench for prng256_sched with an 11-cycle PRNG model,
// a queue-based scoreboard of expected counters/results and a per-cycle checker.
module tb_prng256_sched;

    localparam int CNT_W = 32;
    localparam int DEPTH = 8;
    localparam int PIPE  = 11;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [127:0]       cfg_key = '0;
    logic [6:0]         cfg_prefix = '0;
    logic [CNT_W-1:0]   cfg_cnt_base = '0;
    logic [CNT_W-1:0]   cfg_nblk = '0;
    logic               start = 1'b0;
    logic               busy, done, prng_drdy, m_valid, err_unexp;
    logic [127:0]       prng_kin;
    logic [6:0]         prng_prefix;
    logic [CNT_W-1:0]   prng_cnt;
    logic               prng_dvld = 1'b0;
    logic [255:0]       prng_dout = '0;
    logic [255:0]       m_data;
    logic               m_ready = 1'b0;

    prng256_sched #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .cfg_key(cfg_key), .cfg_prefix(cfg_prefix),
        .cfg_cnt_base(cfg_cnt_base), .cfg_nblk(cfg_nblk),
        .start(start), .busy(busy), .done(done),
        .prng_kin(prng_kin), .prng_prefix(prng_prefix),
        .prng_cnt(prng_cnt), .prng_drdy(prng_drdy),
        .prng_dvld(prng_dvld), .prng_dout(prng_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_unexp(err_unexp)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Stand-in for the AES pair: any keyed, counter-dependent value will do.
    function automatic logic [255:0] prng_fn(input logic [127:0] k, input logic [6:0] p,
                                             input logic [31:0] c);
        return {k ^ {96'd0, c}, {c, 89'd0, p} ^ ~k};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // PRNG model: a result appears exactly PIPE cycles after its issue strobe.
    logic         pv [PIPE] = '{default: 1'b0};
    logic [255:0] pd [PIPE] = '{default: '0};
    always @(posedge CLK) begin
        #1;
        prng_dvld = pv[PIPE-1];
        prng_dout = pd[PIPE-1];
        for (int i = PIPE - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = prng_drdy;
        pd[0] = prng_fn(prng_kin, prng_prefix, prng_cnt);
    end

    // Scoreboard state
    logic [31:0]  exp_cnt_q [$];
    logic [255:0] exp_data_q [$];
    logic [127:0] exp_key = '0;
    logic [6:0]   exp_prefix = '0;
    logic         exp_err = 1'b0;
    int           inflight_m = 0;
    logic [31:0]  drdy_log [$];
    int           drdy_cyc [$];
    int           pop_n = 0;
    int           last_pop_cyc = 0;
    int           done_n = 0;
    int           done_cyc = 0;
    int           start_cyc = 0;

    // Per-cycle compare against the scoreboard.
    always @(negedge CLK) begin
        if (RST) begin
            exp_err    = 1'b0;
            inflight_m = 0;
        end else begin
            chk("err_unexp", err_unexp, exp_err);
            if (prng_drdy) begin
                drdy_log.push_back(prng_cnt);
                drdy_cyc.push_back(cyc);
                if (exp_cnt_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL drdy_unexp: got issue of %h, expected no issue", prng_cnt);
                end else begin
                    chk("prng_cnt", prng_cnt, exp_cnt_q.pop_front());
                    chk("prng_kin", prng_kin, exp_key);
                    chk("prng_prefix", prng_prefix, exp_prefix);
                end
                inflight_m++;
            end
            if (m_valid && m_ready) begin
                if (exp_data_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexp: got beat %h, expected none", m_data);
                end else begin
                    chk("m_data", m_data, exp_data_q.pop_front());
                end
                pop_n++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (prng_dvld) begin
                if (inflight_m == 0) exp_err = 1'b1;
                else inflight_m--;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] nblk,
                             input logic [127:0] key, input logic [6:0] pfx);
        cfg_cnt_base = base;
        cfg_nblk     = nblk;
        cfg_key      = key;
        cfg_prefix   = pfx;
        start        = 1'b1;
        exp_key      = key;
        exp_prefix   = pfx;
        for (int i = 0; i < int'(nblk); i++) begin
            exp_cnt_q.push_back(base + 32'(i));
            exp_data_q.push_back(prng_fn(key, pfx, base + 32'(i)));
        end
        start_cyc = cyc;
        tick();
        start        = 1'b0;
        cfg_cnt_base = ~base;
        cfg_nblk     = nblk + 32'd5;
        cfg_key      = ~key;
        cfg_prefix   = ~pfx;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_n;
        k  = 0;
        while (done_n == d0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", done_n != d0, 1'b1);
        chk("busy_after_done", busy, 1'b0);
        chk("done_width", done, 1'b0);
        chk("cnt_q_empty", exp_cnt_q.size(), 0);
        chk("data_q_empty", exp_data_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_drdy"}, prng_drdy, 1'b0);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_data"}, m_data, '0);
        chk({tag, "_err"}, err_unexp, 1'b0);
        chk({tag, "_cnt"}, prng_cnt, '0);
        chk({tag, "_kin"}, prng_kin, '0);
        chk({tag, "_prefix"}, prng_prefix, '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        int p0;
        int d0;
        int k;
        logic [31:0] t1_exp [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
        logic [31:0] t3_exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

        // Reset state
        RST = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        RST = 1'b0;
        tick();

        // 1: four blocks at full throughput
        m_ready = 1'b1;
        b = drdy_log.size();
        start_job(32'h10, 32'd4, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 7'h2A);
        chk("t1_busy", busy, 1'b1);
        wait_done(80);
        for (int i = 0; i < 4; i++) begin
            chk("t1_cnt_lit", drdy_log[b+i], t1_exp[i]);
            chk("t1_back_to_back", drdy_cyc[b+i], drdy_cyc[b] + i);
        end
        chk("t1_done_after_pop", done_cyc, last_pop_cyc + 1);
        chk("t1_pin_model", prng_fn(128'h1, 7'h0, 32'h10), {128'h11, {32'h10, 96'd0} ^ ~128'h1});

        // 2: consumer stalled; issue must stop at FIFO_DEPTH credits
        m_ready = 1'b0;
        b  = drdy_log.size();
        p0 = pop_n;
        start_job(32'h100, 32'd20, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 7'h05);
        repeat (40) tick();
        chk("t2_issue_stall", drdy_log.size() - b, 8);
        chk("t2_m_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        wait_done(200);
        chk("t2_beats", pop_n - p0, 20);
        chk("t2_err", err_unexp, 1'b0);

        // 3: counter wrap
        b = drdy_log.size();
        start_job(32'hFFFF_FFFE, 32'd4, 128'hDEAD_BEEF, 7'h7F);
        wait_done(80);
        for (int i = 0; i < 4; i++)
            chk("t3_wrap_lit", drdy_log[b+i], t3_exp[i]);

        // 4: empty job
        b  = drdy_log.size();
        p0 = pop_n;
        start_job(32'h55, 32'd0, 128'h77, 7'h01);
        wait_done(10);
        chk("t4_done_time", done_cyc, start_cyc + 1);
        chk("t4_no_issue", drdy_log.size() - b, 0);
        chk("t4_no_beats", pop_n - p0, 0);

        // 5: start while busy is ignored
        b  = drdy_log.size();
        p0 = pop_n;
        d0 = done_n;
        start_job(32'h2000, 32'd6, 128'h1357_9BDF, 7'h11);
        tick();
        tick();
        cfg_cnt_base = 32'h9000;
        cfg_nblk     = 32'd3;
        cfg_key      = 128'hBAD;
        cfg_prefix   = 7'h44;
        start        = 1'b1;
        tick();
        start = 1'b0;
        wait_done(80);
        repeat (4) tick();
        chk("t5_issues", drdy_log.size() - b, 6);
        chk("t5_beats", pop_n - p0, 6);
        chk("t5_one_done", done_n - d0, 1);

        // 6: reset with three blocks in flight, then a fresh job
        b = drdy_log.size();
        start_job(32'h3000, 32'd10, 128'hCAFE, 7'h33);
        k = 0;
        while ((drdy_log.size() - b) < 2 && k < 40) begin
            tick();
            k++;
        end
        chk("t6_reach_issue", (drdy_log.size() - b) >= 2, 1'b1);
        RST = 1'b1;
        exp_cnt_q.delete();
        exp_data_q.delete();
        tick();
        chk_all_zero("t6_reset");
        RST = 1'b0;
        repeat (20) tick();
        chk("t6_err_sticky", err_unexp, 1'b1);
        chk("t6_idle", busy, 1'b0);
        p0 = pop_n;
        start_job(32'h40, 32'd3, 128'hF00D, 7'h12);
        wait_done(80);
        chk("t6_fresh_beats", pop_n - p0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
